nonce_sweep_ctrl: RTL
=====================

Name: nonce_sweep_ctrl

Overview:
- Sequences the double-SHA256 hashing core through a nonce range for one mining job.
- Latches a job (midstate, merkle tail, timestamp, nbits, nonce range, difficulty), then issues one message block per cycle into the fixed-latency pipelined core.
- Checks every returned hash2 against a leading-zero difficulty and queues winning nonces in a small FIFO for the serial readout side.
- Sits between the SPI job registers and the hashing core, replacing the free-running static feed.

Parameters:
PIPE_LAT, 128, fixed cycles from core input to matching core_hash2 output (≥1)
HIT_DEPTH, 4, hit FIFO entries (power of two, ≥2)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
job_valid  input  1  job offered
job_ready  output  1  controller accepts job (high only in IDLE)
job_midstate  input  256  state0 for core
job_merkle_last_32  input  32  block word 16
job_timestamp  input  32  block word 17
job_nbits  input  32  block word 18
job_nonce_start  input  32  first nonce
job_nonce_end  input  32  last nonce, inclusive
job_zero_bits  input  8  required leading zero bits of hash2 (0..255)
abort  input  1  stop sweep
core_hash0  output  256  to core hash0
core_data1  output  512  to core data1
core_hash2  input  256  from core
hit_valid  output  1  FIFO non-empty
hit_ready  input  1  consumer pops head
hit_nonce  output  32  FIFO head
hit_overflow  output  1  sticky: hit dropped while FIFO full
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at sweep end

Behaviour:
- Reset: state IDLE; all outputs 0 except job_ready=1; FIFO emptied; in-flight valid line cleared; core_hash0/core_data1 = 0.
- core_data1 = {merkle_last_32, timestamp, nbits, nonce, 384'h8000_0000 followed by zeros ending in 32'h0000_0280}; nonce = current issue nonce. core_hash0 = latched midstate.
- States: IDLE, SWEEP, DRAIN.
- IDLE: on job_valid&&job_ready, latch all job fields; issue_nonce=start; remaining = (end - start) mod 2^32 + 1, held in a 33-bit counter (start==end → 1 nonce; end=start-1 → 2^32 nonces; end<start wraps through FFFF_FFFF). Next: SWEEP.
- SWEEP: each cycle, issue one nonce; push 1 into a PIPE_LAT-deep valid shift line; issue_nonce+1 (wraps mod 2^32); remaining-1. After the cycle issuing the last nonce, go to DRAIN.
- DRAIN: push 0 into the valid line. Exit to IDLE when the line is all zero. done pulses for exactly 1 cycle in that transition cycle. job_ready returns high the following cycle.
- Result side: a check_nonce register loads start on job accept and increments each cycle the valid-line output bit is 1. The output bit qualifies core_hash2 in that cycle. Hit when job_zero_bits==0 or core_hash2[255 -: job_zero_bits]==0.
- FIFO: on a hit, push check_nonce if not full. If full, drop it and set hit_overflow. hit_overflow is sticky; it clears only at the next job accept or reset. Pop on hit_valid&&hit_ready. A simultaneous push and pop while full is accepted, with no overflow. hit_nonce is the registered head. The FIFO is not cleared on job accept; unread hits persist.
- abort (SWEEP or DRAIN): stop issuing immediately; clear the valid line; enter IDLE next cycle. No done pulse. FIFO contents are kept. abort in IDLE is ignored.
- job_valid is ignored outside IDLE.
- Reset mid-sweep: everything returns to its reset values asynchronously; no partial hits are reported.
- Throughput: 1 nonce/cycle. Sweep of N nonces takes N+PIPE_LAT cycles from accept to done.

Test Plan:
- PIPE_LAT=4, behavioural core model. Job start=0x10, end=0x13, zero_bits=0, all hashes nonzero -> hits 0x10,0x11,0x12,0x13 in order; done exactly 8 cycles after accept; busy high for 8 cycles.
- zero_bits=8; model returns hash2 MSB byte 0x00 only for nonce 0x1234 in range 0x1230..0x123F -> exactly one hit, hit_nonce=0x1234, no overflow.
- Wrap: start=0xFFFF_FFFE, end=0x0000_0001, zero_bits=0 -> 4 hits FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001; start==end=0x55 -> single hit 0x55.
- HIT_DEPTH=4, hit_ready=0, 6 always-hit nonces -> FIFO holds first 4, hit_overflow=1. Then pop all -> 4 nonces in order, hit_valid=0, overflow remains 1 until the next job accept.
- Abort at 3rd SWEEP cycle of a 100-nonce job -> IDLE next cycle, no done, no hits from nonces in flight; new job accepted immediately.
- Assert rst_n low mid-DRAIN with 2 queued hits -> outputs at reset values asynchronously, FIFO empty, job_ready=1 after release.

Source files
------------

// File: rtl/nonce_sweep_ctrl_if.sv
// nonce_sweep_ctrl_if: job, hashing-core and hit-readout signals of the nonce sweep controller
interface nonce_sweep_ctrl_if;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [31:0]  job_merkle_last_32;
  logic [31:0]  job_timestamp;
  logic [31:0]  job_nbits;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic [7:0]   job_zero_bits;
  logic         abort;
  logic [255:0] core_hash0;
  logic [511:0] core_data1;
  logic [255:0] core_hash2;
  logic         hit_valid;
  logic         hit_ready;
  logic [31:0]  hit_nonce;
  logic         hit_overflow;
  logic         busy;
  logic         done;
  modport master (
    output job_valid, job_midstate, job_merkle_last_32, job_timestamp, job_nbits,
           job_nonce_start, job_nonce_end, job_zero_bits, abort, core_hash2, hit_ready,
    input  job_ready, core_hash0, core_data1, hit_valid, hit_nonce, hit_overflow, busy, done
  );
  modport slave (
    input  job_valid, job_midstate, job_merkle_last_32, job_timestamp, job_nbits,
           job_nonce_start, job_nonce_end, job_zero_bits, abort, core_hash2, hit_ready,
    output job_ready, core_hash0, core_data1, hit_valid, hit_nonce, hit_overflow, busy, done
  );
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: feeds one nonce per cycle into the hashing core and queues nonces whose hash2 meets the difficulty
module nonce_sweep_ctrl #(
  parameter int PIPE_LAT  = 128,
  parameter int HIT_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  nonce_sweep_ctrl_if.slave bus
);
  localparam int AW = $clog2(HIT_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(HIT_DEPTH);
  localparam logic [383:0] PAD = {32'h8000_0000, 320'h0, 32'h0000_0280};
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  state_t state_q, state_d;
  logic [255:0] midstate_q;
  logic [31:0] merkle_q, ts_q, nbits_q, issue_q, check_q;
  logic [7:0] zbits_q;
  logic [32:0] remaining_q;
  logic [PIPE_LAT-1:0] vline_q, vline_d;
  logic [31:0] mem_q [HIT_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic ovf_q, accept, stop, chk, hit, push, pop, full, wr_en;
  assign accept = state_q == IDLE && bus.job_valid;
  assign stop = state_q != IDLE && bus.abort;
  assign chk = vline_q[PIPE_LAT-1] && !stop;
  assign hit = ~|(bus.core_hash2 & ~({256{1'b1}} >> zbits_q));
  assign push = chk && hit;
  assign pop = bus.hit_valid && bus.hit_ready;
  assign full = cnt_q == FULL;
  assign wr_en = push && (!full || pop);
  // Valid line tracks which core pipeline slots hold a real nonce; abort flushes it
  always_comb vline_d = stop ? '0 : (vline_q << 1) | PIPE_LAT'(state_q == SWEEP);
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Next state: drain ends once the valid line empties after this shift
  always_comb
    state_d = stop ? IDLE :
              accept ? SWEEP :
              (state_q == SWEEP && remaining_q == 33'd1) ? DRAIN :
              (state_q == DRAIN && vline_d == '0) ? IDLE : state_q;
  // Outputs decoded from state; the block is only presented while issuing
  always_comb begin
    bus.job_ready = state_q == IDLE;
    bus.busy = state_q != IDLE;
    bus.done = state_q == DRAIN && !bus.abort && vline_d == '0;
    bus.core_data1 = state_q == SWEEP ? {merkle_q, ts_q, nbits_q, issue_q, PAD} : '0;
  end
  assign bus.core_hash0 = midstate_q;
  assign bus.hit_valid = cnt_q != '0;
  assign bus.hit_nonce = bus.hit_valid ? mem_q[rd_q] : '0;
  assign bus.hit_overflow = ovf_q;
  // Job latch, issue/check counters, valid line and hit FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      midstate_q <= '0;
      merkle_q <= '0;
      ts_q <= '0;
      nbits_q <= '0;
      zbits_q <= '0;
      issue_q <= '0;
      check_q <= '0;
      remaining_q <= '0;
      vline_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vline_q <= vline_d;
      if (accept) begin
        midstate_q <= bus.job_midstate;
        merkle_q <= bus.job_merkle_last_32;
        ts_q <= bus.job_timestamp;
        nbits_q <= bus.job_nbits;
        zbits_q <= bus.job_zero_bits;
        issue_q <= bus.job_nonce_start;
        check_q <= bus.job_nonce_start;
        remaining_q <= {1'b0, bus.job_nonce_end - bus.job_nonce_start} + 33'd1;
        ovf_q <= 1'b0;
      end else begin
        if (state_q == SWEEP) begin
          issue_q <= issue_q + 32'd1;
          remaining_q <= remaining_q - 33'd1;
        end
        if (chk) check_q <= check_q + 32'd1;
        if (push && full && !pop) ovf_q <= 1'b1;
      end
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    end
  // Hit storage; occupancy is tracked separately so entries need no reset
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= check_q;
endmodule
